// File: rtl/m_dm_bytelane_pkg.sv
// Shared encodings and byte-lane helpers for the M-stage byte-lane data memory.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: be_of = 4'b0001 << lane;
      SZ_HALF: be_of = 4'b0011 << lane;
      SZ_WORD: be_of = 4'b1111;
      default: be_of = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: lane_replicate = {4{wdata[7:0]}};
      SZ_HALF: lane_replicate = {2{wdata[15:0]}};
      default: lane_replicate = wdata;
    endcase
  endfunction

endpackage

// File: rtl/m_dm_bytelane_if.sv
// Request/response bundle between the M-stage register and the byte-lane data memory.
interface m_dm_bytelane_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic [31:0] rdata;
  logic        rvalid;
  logic        addr_err;
  logic        busy;

  modport master (output req, we, size, uns, addr, wdata, pc,
                  input  rdata, rvalid, addr_err, busy);
  modport slave  (input  req, we, size, uns, addr, wdata, pc,
                  output rdata, rvalid, addr_err, busy);
endinterface

// File: rtl/m_dm_bytelane_load_ext.sv
// Combinational load extractor: selects the addressed lane and sign/zero-extends it.
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: result = uns ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}},  shifted[7:0]};
      SZ_HALF: result = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/m_dm_bytelane.sv
// Byte-lane M-stage data memory with post-reset clear sequencer and registered loads.
// Optional store trace enabled by defining DM_TRACE_EN.
//
//   state    | meaning
//   ST_CLEAR | zeroing word[idx] each cycle, busy=1, requests dropped
//   ST_IDLE  | accepting loads/stores
module m_dm_bytelane
  import dm_pkg::*;
#(
  parameter int          DEPTH_WORDS = 3072,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          AW          = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  m_dm_bytelane_if.slave   bus
);

  localparam logic [32:0]   LIMIT    = 33'(4 * DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  logic [31:0]   mem [DEPTH_WORDS];
  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          busy;

  logic [31:0]   off;
  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic          err, accept, do_store, do_load;
  logic [3:0]    be;
  logic [31:0]   rep, cur, merged, ext;

  always_comb begin
    off      = bus.addr - BASE_ADDR;
    widx     = off[AW+1:2];
    lane     = off[1:0];
    err      = ({1'b0, off} >= LIMIT) || (bus.size == 2'd3) ||
               ((bus.size == SZ_HALF) && off[0]) ||
               ((bus.size == SZ_WORD) && (off[1:0] != 2'b00));
    accept   = bus.req && !busy;
    do_store = accept && !err && bus.we;
    do_load  = accept && !err && !bus.we;
    be       = be_of(bus.size, lane);
    rep      = lane_replicate(bus.size, bus.wdata);
    cur      = mem[widx];
    for (int b = 0; b < 4; b++)
      merged[8*b +: 8] = be[b] ? rep[8*b +: 8] : cur[8*b +: 8];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        busy  = 1'b1;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      end
      ST_IDLE: ;
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Array has no reset; the clear sequencer owns it while busy.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[idx_q] <= '0;
    end else if (do_store) begin
      mem[widx] <= merged;
`ifdef DM_TRACE_EN
      $display("%d@%h: *%h <= %h", $time, bus.pc, {bus.addr[31:2], 2'b00}, merged);
`endif
    end
  end

`ifndef DM_TRACE_EN
  logic unused_pc;
  assign unused_pc = ^bus.pc;
`endif

  dm_load_ext u_ext (
    .word   (cur),
    .lane   (lane),
    .size   (bus.size),
    .uns    (bus.uns),
    .result (ext)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rdata    <= '0;
      bus.rvalid   <= 1'b0;
      bus.addr_err <= 1'b0;
    end else begin
      bus.rvalid   <= do_load;
      bus.addr_err <= accept && err;
      if (do_load) bus.rdata <= ext;
    end
  end

  assign bus.busy = busy;

endmodule

// File: tb/tb_m_dm_bytelane.sv
// Scoreboard bench for m_dm_bytelane (DEPTH_WORDS=16) against a byte-array reference model.
module tb_m_dm_bytelane;

  localparam int DEPTH = 16;
  localparam int NBYTES = 4 * DEPTH;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  m_dm_bytelane_if bus();

  m_dm_bytelane #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          is_err;
    logic [31:0] data;
  } exp_t;

  exp_t        expq[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [7:0]  ref_mem [NBYTES];
  logic [31:0] last_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic int nbytes_of(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit ref_err(input logic [31:0] addr, input logic [1:0] size);
    if (size == 2'd3) return 1'b1;
    if (addr >= 32'(NBYTES)) return 1'b1;
    if (addr % nbytes_of(size) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size, input logic uns);
    int n = nbytes_of(size);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[addr + i]) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic ref_clear();
    for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
    last_rdata = 32'h0;
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    bus.req   = 1'b1;
    bus.we    = we;
    bus.size  = size;
    bus.uns   = uns;
    bus.addr  = addr;
    bus.wdata = wdata;
    bus.pc    = 32'h3000 + addr;
    if (ref_err(addr, size)) begin
      e.is_err = 1'b1;
      e.data   = last_rdata;
      expq.push_back(e);
    end else if (we) begin
      for (int i = 0; i < nbytes_of(size); i++) ref_mem[addr + i] = 8'(wdata >> (8 * i));
    end else begin
      last_rdata = ref_load(addr, size, uns);
      e.is_err   = 1'b0;
      e.data     = last_rdata;
      expq.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset && (bus.rvalid || bus.addr_err)) begin
      exp_t e;
      check("rvalid_err_exclusive", 32'(bus.rvalid & bus.addr_err), 32'h0);
      if (expq.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL unexpected_output: rvalid=%b addr_err=%b rdata=%h, expected no response",
                 bus.rvalid, bus.addr_err, bus.rdata);
      end else begin
        e = expq.pop_front();
        check("resp_kind_err", 32'(bus.addr_err), 32'(e.is_err));
        check("resp_rdata", bus.rdata, e.data);
      end
    end
  end

  task automatic count_busy(input string name);
    int cnt = 0;
    while (bus.busy && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check(name, 32'(cnt), 32'(DEPTH));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'd0; bus.uns = 1'b0;
    bus.addr = 32'h0; bus.wdata = 32'h0; bus.pc = 32'h0;
    ref_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(bus.busy), 32'h1);
    check("reset_rvalid", 32'(bus.rvalid), 32'h0);
    check("reset_addr_err", 32'(bus.addr_err), 32'h0);
    check("reset_rdata", bus.rdata, 32'h0);

    // Requests held during the clear must be dropped.
    reset = 1'b1;
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd2; bus.addr = 32'h3C; bus.wdata = 32'hFFFF_FFFF;
    fork
      begin
        repeat (5) @(posedge clk);
        #2;
        bus.we = 1'b0;
      end
    join_none
    count_busy("busy_cycles_first_clear");
    bus.req = 1'b0;
    idle(1);

    do_req(1'b0, 2'd2, 1'b0, 32'h3C, 32'h0);
    do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'h1122_3344);
    do_req(1'b0, 2'd0, 1'b0, 32'hB, 32'h0);
    do_req(1'b0, 2'd0, 1'b0, 32'h8, 32'h0);
    do_req(1'b0, 2'd1, 1'b0, 32'hA, 32'h0);
    do_req(1'b1, 2'd0, 1'b0, 32'h5, 32'h80);
    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    do_req(1'b0, 2'd0, 1'b0, 32'h5, 32'h0);
    do_req(1'b0, 2'd0, 1'b1, 32'h5, 32'h0);
    idle(2);
    do_req(1'b0, 2'd1, 1'b0, 32'h3, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h2, 32'h0);
    do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEAD_BEEF);
    do_req(1'b1, 2'd1, 1'b0, 32'h9, 32'hCAFE);
    do_req(1'b1, 2'd3, 1'b0, 32'h8, 32'h5555_5555);
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    do_req(1'b1, 2'd1, 1'b0, 32'h6, 32'hBEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    idle(2);

    // Reset reasserted at clear index 7 restarts the whole sweep.
    reset = 1'b0;
    #2;
    check("rereset_busy", 32'(bus.busy), 32'h1);
    check("rereset_rvalid", 32'(bus.rvalid), 32'h0);
    reset = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd2; bus.addr = 32'h10; bus.wdata = 32'hA5A5_A5A5;
    count_busy("busy_cycles_after_midclear_reset");
    bus.req = 1'b0;
    ref_clear();
    idle(1);
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);

    for (int k = 0; k < 400; k++) begin
      logic [31:0] a;
      logic [1:0]  s;
      s = 2'($urandom_range(0, 3));
      a = $urandom_range(0, NBYTES + 7);
      if ($urandom_range(0, 3) != 0 && s != 2'd3) a = a & ~(32'(nbytes_of(s)) - 1);
      do_req(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    for (int w = 0; w < DEPTH; w++) do_req(1'b0, 2'd2, 1'b0, 32'(4 * w), 32'h0);

    idle(4);
    check("scoreboard_drained", 32'(expq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
